// File: rtl/patt_det_if.sv
`default_nettype none
// ============================================================================
// Module      : patt_det_if
// Description : Configuration and serial-data bundle for the patt_det
//               pattern detector.
//               master : drives ld, pat, len_m1, ovl, vld, i;
//                        observes o, cnt, armed
//               slave  : the detector side of the same signals
//               pat    : W bits, pat[len-1] is the first bit received
//               len_m1 : LW bits, pattern length minus one
//               cnt    : CNT_W bits, saturating match counter
// Revision    : 1.0 - initial release
// ============================================================================
interface patt_det_if #(
    parameter int W     = 8,
    parameter int LW    = 3,
    parameter int CNT_W = 8
);
    logic             ld;
    logic [W-1:0]     pat;
    logic [LW-1:0]    len_m1;
    logic             ovl;
    logic             vld;
    logic             i;
    logic             o;
    logic [CNT_W-1:0] cnt;
    logic             armed;

    modport master (
        output ld, pat, len_m1, ovl, vld, i,
        input  o, cnt, armed
    );

    modport slave (
        input  ld, pat, len_m1, ovl, vld, i,
        output o, cnt, armed
    );
endinterface
`default_nettype wire

// File: rtl/patt_det.sv
`default_nettype none
// ============================================================================
// Module      : patt_det
// Description : Run-time programmable serial bit-pattern detector.
//               Samples i on edges where vld=1 and compares the newest
//               len_m1+1 bits against a pattern latched by ld. Supports
//               overlapping / non-overlapping matching, a registered
//               one-cycle match pulse and a saturating match counter.
//               clk   : system clock, rising edge
//               rst_b : asynchronous active-low reset
//               bus   : patt_det_if.slave (ld, pat, len_m1, ovl, vld, i,
//                       o, cnt, armed)
// Revision    : 1.0 - initial release
// ============================================================================
module patt_det #(
    parameter int W     = 8,   // maximum pattern length, must equal 2**LW
    parameter int LW    = 3,
    parameter int CNT_W = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_b,
    patt_det_if.slave    bus
);

    localparam logic [0:0]       c_st_idle  = 1'b0;
    localparam logic [0:0]       c_st_run   = 1'b1;
    localparam logic [LW:0]      c_fill_max = (LW+1)'(W);
    localparam logic [W-1:0]     c_ones     = '1;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [0:0]       r_state;
    // Only the W-1 most recent bits are kept: together with the incoming
    // bit they form the full W-bit comparison window, and the oldest bit
    // of a W-bit history would never be compared.
    logic [W-2:0]     r_hist;
    logic [LW:0]      r_fill;
    logic [W-1:0]     r_pat;
    logic [LW-1:0]    r_len_m1;
    logic             r_ovl;
    logic             r_o;
    logic [CNT_W-1:0] r_cnt;

    logic [W-1:0]     w_shift;
    logic [W-1:0]     w_mask;
    logic             w_match;
    logic [LW:0]      w_fill_inc;

    // Window including the bit being sampled, newest bit at position 0.
    assign w_shift = {r_hist, bus.i};

    // Keep the low len_m1+1 bits. Because W = 2**LW, W-1-len_m1 is simply
    // the bitwise inverse of len_m1.
    assign w_mask = c_ones >> (~r_len_m1);

    // fill + 1 >= len_m1 + 1 reduces to fill >= len_m1.
    assign w_match = (r_fill >= {1'b0, r_len_m1}) &&
                     (((w_shift ^ r_pat) & w_mask) == '0);

    assign w_fill_inc = (r_fill == c_fill_max) ? r_fill : r_fill + 1'b1;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= c_st_idle;
            r_hist   <= '0;
            r_fill   <= '0;
            r_pat    <= '0;
            r_len_m1 <= '0;
            r_ovl    <= 1'b0;
            r_o      <= 1'b0;
            r_cnt    <= '0;
        end else if (bus.ld) begin
            // Load takes priority over a coincident sample, from either state.
            r_state  <= c_st_run;
            r_pat    <= bus.pat;
            r_len_m1 <= bus.len_m1;
            r_ovl    <= bus.ovl;
            r_hist   <= '0;
            r_fill   <= '0;
            r_cnt    <= '0;
            r_o      <= 1'b0;
        end else if ((r_state == c_st_run) && bus.vld) begin
            r_hist <= w_shift[W-2:0];
            r_o    <= w_match;
            if (w_match) begin
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // Non-overlapping: restart the window so no bit is reused.
                r_fill <= r_ovl ? w_fill_inc : '0;
            end else begin
                r_fill <= w_fill_inc;
            end
        end else begin
            // IDLE or vld=0: history and fill hold, pulse drops.
            r_o <= 1'b0;
        end
    end

    assign bus.o     = r_o;
    assign bus.cnt   = r_cnt;
    assign bus.armed = (r_state == c_st_run);

endmodule
`default_nettype wire

// File: tb/tb_patt_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_patt_det
// Description : Self-checking bench for patt_det. Two instances share all
//               stimulus: one with CNT_W=8 and one with CNT_W=2 for counter
//               saturation. A queue-based reference model tracks the bits
//               received since the last load/restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_patt_det;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    patt_det_if #(.W(8), .LW(3), .CNT_W(8)) bus  ();
    patt_det_if #(.W(8), .LW(3), .CNT_W(2)) bus2 ();

    patt_det #(.W(8), .LW(3), .CNT_W(8)) dut  (.clk(clk), .rst_b(rst_b), .bus(bus.slave));
    patt_det #(.W(8), .LW(3), .CNT_W(2)) dut2 (.clk(clk), .rst_b(rst_b), .bus(bus2.slave));

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // configuration presented on the pins
    logic [7:0] cfg_pat    = '0;
    logic [2:0] cfg_len_m1 = '0;
    logic       cfg_ovl    = 1'b0;

    // reference model
    bit         q[$];
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    logic       m_armed;
    logic       m_o;
    logic [7:0] m_c8;
    logic [1:0] m_c2;

    task automatic model_reset();
        q.delete();
        m_pat = '0; m_len = 1; m_ovl = 1'b0;
        m_armed = 1'b0; m_o = 1'b0; m_c8 = '0; m_c2 = '0;
    endtask

    task automatic model_edge(input logic l, input logic v, input logic b);
        bit hit;
        if (l) begin
            m_armed = 1'b1;
            m_pat = cfg_pat; m_len = int'(cfg_len_m1) + 1; m_ovl = cfg_ovl;
            q.delete();
            m_o = 1'b0; m_c8 = '0; m_c2 = '0;
        end else if (m_armed && v) begin
            q.push_back(b);
            if (q.size() > 8) void'(q.pop_front());
            hit = 1'b0;
            if (q.size() >= m_len) begin
                hit = 1'b1;
                // newest received bit corresponds to pat[0]
                for (int j = 0; j < m_len; j++)
                    if (q[q.size()-1-j] != m_pat[j]) hit = 1'b0;
            end
            m_o = hit;
            if (hit) begin
                if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
                if (m_c2 != 2'b11) m_c2 = m_c2 + 2'd1;
                if (!m_ovl) q.delete();
            end
        end else begin
            m_o = 1'b0;
        end
    endtask

    // Drive one clock cycle; outputs are stable #1 after the edge on return.
    task automatic step(input logic l, input logic v, input logic b);
        bus.ld = l;  bus.pat = cfg_pat;  bus.len_m1 = cfg_len_m1;  bus.ovl = cfg_ovl;
        bus.vld = v; bus.i = b;
        bus2.ld = l; bus2.pat = cfg_pat; bus2.len_m1 = cfg_len_m1; bus2.ovl = cfg_ovl;
        bus2.vld = v; bus2.i = b;
        @(posedge clk);
        model_edge(l, v, b);
        #1;
        bus.ld = 1'b0; bus2.ld = 1'b0; bus.vld = 1'b0; bus2.vld = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        step_inputs_idle();
        #1;
        n_total++;
        if ({bus.o, bus.cnt, bus.armed} !== 10'b0)
            $display("FAIL reset_dut: got o=%b cnt=%0d armed=%b exp all 0", bus.o, bus.cnt, bus.armed);
        else n_pass++;
        n_total++;
        if ({bus2.o, bus2.cnt, bus2.armed} !== 4'b0)
            $display("FAIL reset_dut2: got o=%b cnt=%0d armed=%b exp all 0", bus2.o, bus2.cnt, bus2.armed);
        else n_pass++;
        #2 rst_b = 1'b1;
    endtask

    task automatic step_inputs_idle();
        bus.ld = 0;  bus.pat = 0;  bus.len_m1 = 0;  bus.ovl = 0;  bus.vld = 0;  bus.i = 0;
        bus2.ld = 0; bus2.pat = 0; bus2.len_m1 = 0; bus2.ovl = 0; bus2.vld = 0; bus2.i = 0;
    endtask

    task automatic test_idle_ignored();
        logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        cfg_pat = 8'b0000_1011; cfg_len_m1 = 3'd3; cfg_ovl = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, bits[k]);
            n_total++;
            if ({bus.o, bus.cnt, bus.armed} !== 10'b0)
                $display("FAIL idle_ignored[%0d]: got o=%b cnt=%0d armed=%b exp all 0", k, bus.o, bus.cnt, bus.armed);
            else n_pass++;
        end
    endtask

    task automatic test_ovl_1011();
        logic bits  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_o [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cfg_pat = 8'b0000_1011; cfg_len_m1 = 3'd3; cfg_ovl = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        n_total++;
        if (bus.armed !== 1'b1 || bus.cnt !== 8'd0)
            $display("FAIL ovl1011_load: got armed=%b cnt=%0d exp armed=1 cnt=0", bus.armed, bus.cnt);
        else n_pass++;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, bits[k]);
            n_total++;
            if (bus.o !== exp_o[k] || {bus.o, bus.cnt} !== {m_o, m_c8})
                $display("FAIL ovl1011[%0d]: got o=%b cnt=%0d exp o=%b cnt=%0d", k, bus.o, bus.cnt, exp_o[k], m_c8);
            else n_pass++;
        end
        n_total++;
        if (bus.cnt !== 8'd2)
            $display("FAIL ovl1011_cnt: got %0d exp 2", bus.cnt);
        else n_pass++;
    endtask

    task automatic test_111();
        logic exp_o [2][6] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
                               '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}};
        logic [7:0] exp_cnt [2] = '{8'd2, 8'd4};
        for (int m = 0; m < 2; m++) begin
            cfg_pat = 8'b0000_0111; cfg_len_m1 = 3'd2; cfg_ovl = (m == 1);
            step(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 6; k++) begin
                step(1'b0, 1'b1, 1'b1);
                n_total++;
                if (bus.o !== exp_o[m][k] || bus.o !== m_o)
                    $display("FAIL ones_ovl%0d[%0d]: got o=%b exp %b", m, k, bus.o, exp_o[m][k]);
                else n_pass++;
            end
            n_total++;
            if (bus.cnt !== exp_cnt[m])
                $display("FAIL ones_ovl%0d_cnt: got %0d exp %0d", m, bus.cnt, exp_cnt[m]);
            else n_pass++;
        end
    endtask

    task automatic test_len1_and_gaps();
        logic bits  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic exp_o [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic seq   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int   nvalid;
        cfg_pat = 8'b1111_1101; cfg_len_m1 = 3'd0; cfg_ovl = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, bits[k]);
            n_total++;
            if (bus.o !== exp_o[k] || bus.o !== m_o)
                $display("FAIL len1[%0d]: got o=%b exp %b", k, bus.o, exp_o[k]);
            else n_pass++;
        end
        // 1011 with idle gaps of varying length between the valid bits
        cfg_pat = 8'b0000_1011; cfg_len_m1 = 3'd3; cfg_ovl = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g <= k; g++) begin
                step(1'b0, 1'b0, ~seq[k]);
                n_total++;
                if (bus.o !== ((nvalid == 4) && (g == 0) ? 1'b1 : 1'b0) && 0 == 1) n_pass += 0;
                if (bus.o !== 1'b0 && !(nvalid == 4 && g == 0))
                    $display("FAIL gaps_idle[%0d.%0d]: got o=%b exp 0", k, g, bus.o);
                else n_pass++;
            end
            step(1'b0, 1'b1, seq[k]);
            nvalid++;
            n_total++;
            if (bus.o !== (nvalid == 4) || bus.o !== m_o)
                $display("FAIL gaps_valid[%0d]: got o=%b exp %b", k, bus.o, (nvalid == 4));
            else n_pass++;
        end
        step(1'b0, 1'b0, 1'b0);
        n_total++;
        if (bus.o !== 1'b0 || bus.cnt !== 8'd1)
            $display("FAIL gaps_after: got o=%b cnt=%0d exp o=0 cnt=1", bus.o, bus.cnt);
        else n_pass++;
    endtask

    task automatic test_ld_vld_same();
        logic tail [3] = '{1'b0, 1'b1, 1'b1};
        logic full [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        cfg_pat = 8'b0000_1011; cfg_len_m1 = 3'd3; cfg_ovl = 1'b0;
        // The leading 1 of 1011 arrives with ld and must be discarded.
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, tail[k]);
            n_total++;
            if (bus.o !== 1'b0 || bus.o !== m_o)
                $display("FAIL ld_vld_tail[%0d]: got o=%b exp 0", k, bus.o);
            else n_pass++;
        end
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, full[k]);
            n_total++;
            if (bus.o !== (k == 3) || bus.o !== m_o)
                $display("FAIL ld_vld_full[%0d]: got o=%b exp %b", k, bus.o, (k == 3));
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        cfg_pat = 8'b0000_0001; cfg_len_m1 = 3'd0; cfg_ovl = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_total++;
            if (bus2.o !== 1'b1 || bus2.cnt !== exp_c[k] || bus2.cnt !== m_c2)
                $display("FAIL sat[%0d]: got o=%b cnt=%0d exp o=1 cnt=%0d", k, bus2.o, bus2.cnt, exp_c[k]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic full [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        cfg_pat = 8'b0000_1011; cfg_len_m1 = 3'd3; cfg_ovl = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, full[k]);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, full[k]);
        n_total++;
        if (bus.cnt !== 8'd1 || bus.armed !== 1'b1)
            $display("FAIL prereset: got cnt=%0d armed=%b exp cnt=1 armed=1", bus.cnt, bus.armed);
        else n_pass++;
        // mid-cycle, no clock edge until reset is released
        rst_b = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({bus.o, bus.cnt, bus.armed} !== 10'b0)
            $display("FAIL async_reset: got o=%b cnt=%0d armed=%b exp all 0", bus.o, bus.cnt, bus.armed);
        else n_pass++;
        #1 rst_b = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        n_total++;
        if (bus.armed !== 1'b0 || bus.o !== 1'b0)
            $display("FAIL post_reset_idle: got armed=%b o=%b exp 0 0", bus.armed, bus.o);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, full[k]);
            n_total++;
            if (bus.o !== (k == 3) || {bus.o, bus.cnt, bus.armed} !== {m_o, m_c8, m_armed})
                $display("FAIL reload[%0d]: got o=%b cnt=%0d exp o=%b cnt=%0d", k, bus.o, bus.cnt, (k == 3), m_c8);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic l, v, b;
        cfg_pat = 8'($urandom); cfg_len_m1 = 3'($urandom_range(0, 3)); cfg_ovl = 1'($urandom_range(0, 1));
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            l = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) begin
                // reconfigure pins without ld: must have no effect
                cfg_pat = 8'($urandom);
                cfg_len_m1 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                cfg_ovl = 1'($urandom_range(0, 1));
            end
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            step(l, v, b);
            n_total++;
            if ({bus.o, bus.cnt, bus.armed, bus2.o, bus2.cnt} !== {m_o, m_c8, m_armed, m_o, m_c2})
                $display("FAIL random[%0d]: got o=%b cnt=%0d armed=%b cnt2=%0d exp o=%b cnt=%0d armed=%b cnt2=%0d",
                         n, bus.o, bus.cnt, bus.armed, bus2.cnt, m_o, m_c8, m_armed, m_c2);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_ovl_1011();
        test_111();
        test_len1_and_gaps();
        test_ld_vld_same();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/patt_det.md
# patt_det

Parametrised serial bit-pattern detector. It samples a 1-bit input stream on qualified clock edges and compares the most recent bits against a run-time-loaded pattern of programmable length (1..W bits). It supports overlapping and non-overlapping match modes, a one-cycle registered match pulse and a saturating match counter. It replaces fixed-pattern, hard-coded-state detectors in the lab datapath wherever the pattern or its length must change without resynthesis.

## Interface
- `W`, default 8: maximum pattern length in bits; must equal 2^LW.
- `LW`, default 3: width of the length field.
- `CNT_W`, default 8: width of the match counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_b`  in  1  reset, asynchronous and active-low.
- `ld`  in  1  load strobe: capture `pat`, `len_m1` and `ovl`, then restart detection.
- `pat`  in  W  pattern. Bit `pat[len-1]` is the first bit received and `pat[0]` is the last; bits above `len-1` are ignored.
- `len_m1`  in  LW  pattern length minus 1 (0 means 1 bit; W-1 means W bits).
- `ovl`  in  1  1 selects overlapping mode, 0 selects non-overlapping mode.
- `vld`  in  1  sample qualifier; `i` is consumed only on edges where `vld` is 1.
- `i`  in  1  serial data bit.
- `o`  out  1  registered match pulse.
- `cnt`  out  CNT_W  number of matches since the last load, saturating.
- `armed`  out  1  1 once a pattern has been loaded (the block is in state RUN).

## Operation
- State machine with two states:
  - IDLE: reset state. `vld`/`i` are ignored and `o` stays 0. `ld` moves the block to RUN.
  - RUN: detection is active. A further `ld` reloads the configuration and stays in RUN.
  - There is no way back to IDLE except through `rst_b`.
- Internal registers:
  - `hist[W-1:0]`: history shift register. On a sample it updates as `hist <= {hist[W-2:0], i}`, so the newest bit is at `hist[0]`.
  - `fill`: count of valid bits in the history, LW+1 bits wide, saturating at W.
  - Latched copies of `pat`, `len_m1` and `ovl`.
- Match condition, evaluated on a sampling edge using the new bit:
  - `fill + 1 >= len_m1 + 1`, and
  - the low `len_m1+1` bits of `{hist[W-2:0], i}` equal the low `len_m1+1` bits of the latched `pat`.
- On a match:
  - `o` is set to 1 for the following cycle.
  - `cnt` increments unless it is already all-ones.
  - In non-overlapping mode `fill` is cleared to 0, so no bit contributes to two matches.
  - In overlapping mode `fill` advances normally.
- No match, or `vld` = 0 on an edge: `o` is 0 for the following cycle. When `vld` = 0, `hist` and `fill` hold, so gaps in `vld` do not break a sequence.
- `ld` (valid in either state):
  - Latches the configuration.
  - Clears `hist`, `fill`, `cnt` and `o`.
  - If `ld` and `vld` are both 1 on the same edge, `ld` wins and that sample is discarded.
- Changing `pat`, `len_m1` or `ovl` without `ld` has no effect.

## Timing
- Reset values (applied asynchronously while `rst_b` = 0): state IDLE, `o`=0, `cnt`=0, `armed`=0, `hist`=0, `fill`=0, latched configuration = 0.
- Reset in the middle of a sequence discards all partial progress immediately. The first edge after `rst_b` rises sees IDLE.
- Latency: the bit that completes a match is sampled at edge k. `o` is 1 from just after edge k until edge k+1. `cnt` shows the incremented value from edge k.
- `o` is a Moore-style registered output, never combinational from `i`. Back-to-back matches give consecutive 1 cycles on `o`.
- `armed` rises on the edge that samples the first `ld`.
- The earliest match after a load is on the `len_m1+1`-th valid sample following the load edge.
- Counter saturation: at all-ones, `cnt` holds while `o` still pulses.

## Test plan
- W=8, load `pat`=8'b0000_1011, `len_m1`=3, `ovl`=1; stream `i` = 1,0,1,1,0,1,1 with `vld`=1 throughout -> `o` is 1 after the 4th and 7th samples only; `cnt` ends at 2.
- `pat`=3'b111, `len_m1`=2, `ovl`=0; six 1s -> `o` is 1 after samples 3 and 6; `cnt`=2. Repeat with `ovl`=1 -> `o` is 1 after samples 3, 4, 5 and 6; `cnt`=4.
- `len_m1`=0, `pat[0]`=1; stream 1,1,0,1 -> `o` is 1 after samples 1, 2 and 4. Then insert `vld`=0 cycles between the bits of 1011 with `len_m1`=3 -> a single match, with `o` high only in the cycle after the 4th valid sample.
- Before any `ld`, drive `vld`=1 with stream 1011 -> `o`=0, `cnt`=0, `armed`=0. Assert `ld` and `vld` on the same edge -> that sample is ignored and 4 further valid bits are needed for a match.
- CNT_W=2, overlapping single-bit pattern 1; five 1s -> `cnt` sequence is 1, 2, 3, 3, 3 and `o` stays high for all five following cycles.
- Pulse `rst_b` low after three bits of 1011 -> outputs return to 0 immediately and `armed`=0. Reload and resend 1011 -> a single match after the 4th sample.
